// File: rtl/ack_nak_gen.sv
// ack_nak_gen: receive-side data-link sequence checker.
// Classifies each received TLP (accept / duplicate / bad / ahead), tracks
// NEXT_RCV_SEQ, coalesces ACKs behind a timer and issues ACK/NAK DLLPs
// with NAK-scheduled suppression. ack_nak: 00 none, 01 ACK, 10 NAK.
module ack_nak_gen #(
  parameter int SEQ_W       = 12,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx_valid,
  input  logic [SEQ_W-1:0] rx_seq,
  input  logic             rx_crc_ok,
  output logic             tlp_accept,
  output logic             tlp_discard,
  output logic             dllp_valid,
  input  logic             dllp_ready,
  output logic [1:0]       ack_nak,
  output logic [SEQ_W-1:0] ack_seq,
  output logic [SEQ_W-1:0] next_seq,
  output logic             nak_scheduled
);

  // Timer saturates one past the fire point so a pending ACK requests only once.
  localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_ZERO = {TMR_W{1'b0}};
  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
  localparam logic [TMR_W-1:0] TMR_FIRE = TMR_W'(ACK_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] TMR_SAT  = TMR_W'(ACK_TIMEOUT);
  localparam logic [SEQ_W-1:0] SEQ_ZERO = {SEQ_W{1'b0}};
  localparam logic [SEQ_W-1:0] SEQ_ONE  = {{(SEQ_W-1){1'b0}}, 1'b1};
  localparam logic [SEQ_W-1:0] SEQ_HALF = {1'b1, {(SEQ_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND_ACK = 2'd1,
    SEND_NAK = 2'd2
  } state_t;

  state_t             state_r;
  logic               dllp_valid_r;
  logic [1:0]         ack_nak_r;
  logic [SEQ_W-1:0]   ack_seq_r;
  logic [SEQ_W-1:0]   next_seq_r;
  logic               nak_scheduled_r;
  logic               tlp_accept_r;
  logic               tlp_discard_r;
  logic               nak_req_r;
  logic               ack_req_r;
  logic               ack_pending_r;
  logic [TMR_W-1:0]   timer_r;

  logic [SEQ_W-1:0]   diff_s;
  logic               accept_s;
  logic               discard_s;
  logic               set_nak_s;
  logic               set_ack_s;
  logic               timer_fire_s;
  logic               entry_s;
  logic               clr_nak_s;
  logic               clr_ack_s;

  assign tlp_accept    = tlp_accept_r;
  assign tlp_discard   = tlp_discard_r;
  assign dllp_valid    = dllp_valid_r;
  assign ack_nak       = ack_nak_r;
  assign ack_seq       = ack_seq_r;
  assign next_seq      = next_seq_r;
  assign nak_scheduled = nak_scheduled_r;

  // Classify the strobed TLP against NEXT_RCV_SEQ and decide which requests it raises.
  always_comb begin
    diff_s    = next_seq_r - rx_seq;
    accept_s  = 1'b0;
    discard_s = 1'b0;
    set_nak_s = 1'b0;
    set_ack_s = 1'b0;
    if (rx_valid) begin
      if (!rx_crc_ok) begin
        discard_s = 1'b1;
        set_nak_s = !nak_scheduled_r;
      end else if (diff_s == SEQ_ZERO) begin
        accept_s = 1'b1;
      end else if (diff_s <= SEQ_HALF) begin
        // Already received: re-acknowledge so the sender can purge it.
        discard_s = 1'b1;
        set_ack_s = 1'b1;
      end else begin
        // Sequence ahead of expectation: something was lost.
        discard_s = 1'b1;
        set_nak_s = !nak_scheduled_r;
      end
    end else begin
      discard_s = 1'b0;
    end
  end

  // Entry into a send state happens only from IDLE; NAK has priority.
  always_comb begin
    timer_fire_s = ack_pending_r && (timer_r == TMR_FIRE);
    entry_s      = (state_r == IDLE) && (nak_req_r || ack_req_r);
    clr_nak_s    = entry_s && nak_req_r;
    clr_ack_s    = entry_s && !nak_req_r;
  end

  // Receive bookkeeping: accept/discard pulses, NEXT_RCV_SEQ and NAK-scheduled flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tlp_accept_r    <= 1'b0;
      tlp_discard_r   <= 1'b0;
      next_seq_r      <= SEQ_ZERO;
      nak_scheduled_r <= 1'b0;
    end else begin
      tlp_accept_r  <= accept_s;
      tlp_discard_r <= discard_s;
      if (accept_s) begin
        next_seq_r      <= next_seq_r + SEQ_ONE;
        nak_scheduled_r <= 1'b0;
      end else if (set_nak_s) begin
        nak_scheduled_r <= 1'b1;
      end else begin
        nak_scheduled_r <= nak_scheduled_r;
      end
    end
  end

  // Request flags, ACK-pending and coalescing timer; a new set wins over an entry clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      nak_req_r     <= 1'b0;
      ack_req_r     <= 1'b0;
      ack_pending_r <= 1'b0;
      timer_r       <= TMR_ZERO;
    end else begin
      nak_req_r     <= set_nak_s | (nak_req_r & ~clr_nak_s);
      ack_req_r     <= set_ack_s | timer_fire_s | (ack_req_r & ~clr_ack_s);
      ack_pending_r <= accept_s | (ack_pending_r & ~entry_s);
      if (entry_s || !ack_pending_r) begin
        timer_r <= TMR_ZERO;
      end else if (timer_r != TMR_SAT) begin
        timer_r <= timer_r + TMR_ONE;
      end else begin
        timer_r <= timer_r;
      end
    end
  end

  // DLLP FSM: capture the acknowledged sequence on entry, hold until the link takes it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      dllp_valid_r <= 1'b0;
      ack_nak_r    <= 2'b00;
      ack_seq_r    <= SEQ_ZERO;
    end else begin
      case (state_r)
        IDLE: begin
          if (nak_req_r) begin
            state_r      <= SEND_NAK;
            dllp_valid_r <= 1'b1;
            ack_nak_r    <= 2'b10;
            ack_seq_r    <= next_seq_r - SEQ_ONE;
          end else if (ack_req_r) begin
            state_r      <= SEND_ACK;
            dllp_valid_r <= 1'b1;
            ack_nak_r    <= 2'b01;
            ack_seq_r    <= next_seq_r - SEQ_ONE;
          end else begin
            state_r      <= IDLE;
            dllp_valid_r <= 1'b0;
            ack_nak_r    <= 2'b00;
          end
        end
        SEND_ACK, SEND_NAK: begin
          if (dllp_ready) begin
            state_r      <= IDLE;
            dllp_valid_r <= 1'b0;
            ack_nak_r    <= 2'b00;
          end else begin
            state_r <= state_r;
          end
        end
        default: begin
          state_r      <= IDLE;
          dllp_valid_r <= 1'b0;
          ack_nak_r    <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ack_nak_gen.sv
// tb_ack_nak_gen: scenario tasks plus randomized traffic, every cycle compared
// against an event-level reference model of the receive-side ACK/NAK rules.
module tb_ack_nak_gen;

  localparam int SEQ_W = 12;
  localparam int T     = 64;
  localparam int M     = 4096;

  logic             clk;
  logic             reset;
  logic             rx_valid;
  logic [SEQ_W-1:0] rx_seq;
  logic             rx_crc_ok;
  logic             tlp_accept;
  logic             tlp_discard;
  logic             dllp_valid;
  logic             dllp_ready;
  logic [1:0]       ack_nak;
  logic [SEQ_W-1:0] ack_seq;
  logic [SEQ_W-1:0] next_seq;
  logic             nak_scheduled;

  ack_nak_gen #(.SEQ_W(SEQ_W), .ACK_TIMEOUT(T)) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_seq(rx_seq),
    .rx_crc_ok(rx_crc_ok), .tlp_accept(tlp_accept), .tlp_discard(tlp_discard),
    .dllp_valid(dllp_valid), .dllp_ready(dllp_ready), .ack_nak(ack_nak),
    .ack_seq(ack_seq), .next_seq(next_seq), .nak_scheduled(nak_scheduled)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: the DLLP in flight (0 none, 1 ACK, 2 NAK), its sequence,
  // outstanding requests, and the edge at which the oldest unacknowledged
  // accepted TLP started waiting.
  int m_next, m_aseq, m_code, m_since, edge_n;
  bit m_nsched, m_acc, m_dis, m_nreq, m_areq, m_pend;

  logic [29:0] dut_vec;
  logic [29:0] mdl_vec;
  assign dut_vec = {tlp_accept, tlp_discard, dllp_valid, ack_nak, ack_seq, next_seq, nak_scheduled};
  always_comb begin
    mdl_vec = {m_acc, m_dis, (m_code != 0), m_code[1:0], m_aseq[11:0], m_next[11:0], m_nsched};
  end

  task automatic model_reset();
    m_next = 0; m_aseq = 0; m_code = 0; m_since = 0;
    m_nsched = 0; m_acc = 0; m_dis = 0; m_nreq = 0; m_areq = 0; m_pend = 0;
  endtask

  task automatic model_edge(input bit v, input int s, input bit c, input bit r);
    int behind;
    bit acc, dis, want_nak, want_ack, fire, entered;
    acc = 0; dis = 0; want_nak = 0; want_ack = 0; entered = 0;
    edge_n++;
    fire = m_pend && ((edge_n - m_since) == T);
    if (v) begin
      behind = (m_next - s + M) % M;
      if (!c) begin
        dis = 1; want_nak = !m_nsched;
      end else if (behind == 0) begin
        acc = 1;
      end else if (behind <= M / 2) begin
        dis = 1; want_ack = 1;
      end else begin
        dis = 1; want_nak = !m_nsched;
      end
    end
    if (m_code != 0) begin
      if (r) m_code = 0;
    end else if (m_nreq) begin
      m_code = 2; m_aseq = (m_next + M - 1) % M; m_nreq = 0; entered = 1;
    end else if (m_areq) begin
      m_code = 1; m_aseq = (m_next + M - 1) % M; m_areq = 0; entered = 1;
    end
    m_nreq = m_nreq | want_nak;
    m_areq = m_areq | want_ack | fire;
    if (entered) begin
      m_pend = acc; m_since = edge_n;
    end else if (acc && !m_pend) begin
      m_pend = 1; m_since = edge_n;
    end
    if (acc) begin
      m_next = (m_next + 1) % M; m_nsched = 0;
    end else if (want_nak) begin
      m_nsched = 1;
    end
    m_acc = acc; m_dis = dis;
  endtask

  task automatic step(input bit v, input int s, input bit c, input bit r);
    rx_valid = v; rx_seq = s[11:0]; rx_crc_ok = c; dllp_ready = r;
    model_edge(v, s, c, r);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rx_valid = 0; rx_seq = 0; rx_crc_ok = 1; dllp_ready = 0;
    reset = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 0;
    model_reset();
  endtask

  // Stimulus only: accept sequence numbers 0..n-1 back to back.
  task automatic fill_to(input int n);
    for (int i = 0; i < n; i++) step(1, i, 1, 1);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (dut_vec !== 30'd0) begin
      errors++; $display("FAIL reset_values: got %h expected %h", dut_vec, 30'd0);
    end
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 1);
      checks++;
      if (dut_vec !== mdl_vec) begin
        errors++; $display("FAIL reset_idle: got %h expected %h", dut_vec, mdl_vec);
      end
    end
  endtask

  task automatic test_in_order();
    int rise_k, seq_at_rise, code_at_rise;
    bit valid_after;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(1, i, 1, 1);
      checks++;
      if (tlp_accept !== 1'b1 || dut_vec !== mdl_vec) begin
        errors++; $display("FAIL in_order_accept: got %h expected %h", dut_vec, mdl_vec);
      end
    end
    checks++;
    if (next_seq !== 12'd3) begin
      errors++; $display("FAIL in_order_next_seq: got %0d expected 3", next_seq);
    end
    rise_k = 0; seq_at_rise = 0; code_at_rise = 0; valid_after = 1;
    for (int k = 1; k <= T + 4; k++) begin
      step(0, 0, 1, 1);
      checks++;
      if (dut_vec !== mdl_vec) begin
        errors++; $display("FAIL in_order_model: got %h expected %h", dut_vec, mdl_vec);
      end
      if (rise_k != 0 && k == rise_k + 1) valid_after = dllp_valid;
      if (dllp_valid && rise_k == 0) begin
        rise_k = k; seq_at_rise = ack_seq; code_at_rise = ack_nak;
      end
    end
    // The timer runs from the oldest accepted TLP (seq 0), two edges before seq 2.
    checks++;
    if (rise_k != T - 1 || code_at_rise != 1 || seq_at_rise != 2 || valid_after !== 1'b0) begin
      errors++;
      $display("FAIL in_order_timer_ack: got k=%0d code=%0d seq=%0d after=%0b expected k=%0d code=1 seq=2 after=0",
               rise_k, code_at_rise, seq_at_rise, valid_after, T - 1);
    end
  endtask

  task automatic test_nak_crc();
    int nak_rises, nak_seq, disc;
    bit prev_valid;
    do_reset();
    fill_to(5);
    nak_rises = 0; nak_seq = -1; disc = 0; prev_valid = 0;
    for (int j = 0; j < 12; j++) begin
      if (j < 2) step(1, int'($urandom_range(4095, 0)), 0, 1);
      else if (j == 6) step(1, 5, 1, 1);
      else step(0, 0, 1, 1);
      checks++;
      if (dut_vec !== mdl_vec) begin
        errors++; $display("FAIL nak_crc_model: got %h expected %h", dut_vec, mdl_vec);
      end
      if (j < 2 && tlp_discard === 1'b1) disc++;
      if (dllp_valid && !prev_valid && ack_nak == 2'b10) begin
        nak_rises++; nak_seq = ack_seq;
      end
      prev_valid = dllp_valid;
      if (j == 6) begin
        checks++;
        if (tlp_accept !== 1'b1 || nak_scheduled !== 1'b0) begin
          errors++; $display("FAIL nak_crc_good: got acc=%b nsched=%b expected acc=1 nsched=0", tlp_accept, nak_scheduled);
        end
      end
    end
    checks++;
    if (nak_rises != 1 || nak_seq != 4 || disc != 2) begin
      errors++; $display("FAIL nak_crc_single: got naks=%0d seq=%0d disc=%0d expected naks=1 seq=4 disc=2", nak_rises, nak_seq, disc);
    end
  endtask

  task automatic test_duplicate();
    do_reset();
    fill_to(5);
    step(1, 3, 1, 1);
    checks++;
    if (tlp_discard !== 1'b1 || dut_vec !== mdl_vec) begin
      errors++; $display("FAIL dup_discard: got %h expected %h", dut_vec, mdl_vec);
    end
    step(0, 0, 1, 1);
    checks++;
    if (dllp_valid !== 1'b1 || ack_nak !== 2'b01 || ack_seq !== 12'd4 || next_seq !== 12'd5) begin
      errors++; $display("FAIL dup_ack: got v=%b an=%b seq=%0d next=%0d expected v=1 an=01 seq=4 next=5", dllp_valid, ack_nak, ack_seq, next_seq);
    end
  endtask

  task automatic test_ahead();
    int extra;
    bit prev_valid;
    do_reset();
    fill_to(5);
    step(1, 7, 1, 1);
    checks++;
    if (tlp_discard !== 1'b1 || dut_vec !== mdl_vec) begin
      errors++; $display("FAIL ahead_discard: got %h expected %h", dut_vec, mdl_vec);
    end
    step(1, 8, 1, 1);
    checks++;
    if (tlp_discard !== 1'b1 || dllp_valid !== 1'b1 || ack_nak !== 2'b10 || ack_seq !== 12'd4) begin
      errors++; $display("FAIL ahead_nak: got dis=%b v=%b an=%b seq=%0d expected dis=1 v=1 an=10 seq=4", tlp_discard, dllp_valid, ack_nak, ack_seq);
    end
    extra = 0; prev_valid = dllp_valid;
    for (int j = 0; j < 10; j++) begin
      step(0, 0, 1, 1);
      checks++;
      if (dut_vec !== mdl_vec) begin
        errors++; $display("FAIL ahead_model: got %h expected %h", dut_vec, mdl_vec);
      end
      if (dllp_valid && !prev_valid && ack_nak == 2'b10) extra++;
      prev_valid = dllp_valid;
    end
    checks++;
    if (extra != 0 || nak_scheduled !== 1'b1) begin
      errors++; $display("FAIL ahead_suppress: got naks=%0d nsched=%b expected naks=0 nsched=1", extra, nak_scheduled);
    end
  endtask

  task automatic test_wrap();
    bit found;
    do_reset();
    fill_to(4095);
    checks++;
    if (next_seq !== 12'd4095 || dut_vec !== mdl_vec) begin
      errors++; $display("FAIL wrap_fill: got next=%0d vec=%h expected next=4095 vec=%h", next_seq, dut_vec, mdl_vec);
    end
    step(1, 4095, 1, 1);
    checks++;
    if (tlp_accept !== 1'b1 || next_seq !== 12'd0) begin
      errors++; $display("FAIL wrap_accept: got acc=%b next=%0d expected acc=1 next=0", tlp_accept, next_seq);
    end
    found = 0;
    for (int k = 0; k < 2 * T + 8 && !found; k++) begin
      step(0, 0, 1, 1);
      checks++;
      if (dut_vec !== mdl_vec) begin
        errors++; $display("FAIL wrap_model: got %h expected %h", dut_vec, mdl_vec);
      end
      if (dllp_valid && ack_nak == 2'b01 && ack_seq == 12'd4095) found = 1;
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL wrap_ack: got no ACK with seq 4095 expected one within %0d cycles", 2 * T + 8);
    end
    step(0, 0, 1, 1);
    step(1, 4094, 1, 1);
    checks++;
    if (tlp_discard !== 1'b1 || dut_vec !== mdl_vec) begin
      errors++; $display("FAIL wrap_dup: got %h expected %h", dut_vec, mdl_vec);
    end
    step(0, 0, 1, 1);
    checks++;
    if (dllp_valid !== 1'b1 || ack_nak !== 2'b01 || ack_seq !== 12'd4095) begin
      errors++; $display("FAIL wrap_dup_ack: got v=%b an=%b seq=%0d expected v=1 an=01 seq=4095", dllp_valid, ack_nak, ack_seq);
    end
  endtask

  task automatic test_stall();
    bit found;
    do_reset();
    fill_to(5);
    step(1, 9, 0, 0);
    step(0, 0, 1, 0);
    for (int j = 0; j < 10; j++) begin
      if (j == 3) step(1, 5, 1, 0);
      else step(0, 0, 1, 0);
      checks++;
      if (dllp_valid !== 1'b1 || ack_nak !== 2'b10 || ack_seq !== 12'd4 || dut_vec !== mdl_vec) begin
        errors++; $display("FAIL stall_hold: got v=%b an=%b seq=%0d expected v=1 an=10 seq=4", dllp_valid, ack_nak, ack_seq);
      end
    end
    step(0, 0, 1, 1);
    found = 0;
    for (int k = 0; k < 2 * T + 8 && !found; k++) begin
      step(0, 0, 1, 1);
      checks++;
      if (dut_vec !== mdl_vec) begin
        errors++; $display("FAIL stall_model: got %h expected %h", dut_vec, mdl_vec);
      end
      if (dllp_valid && ack_nak == 2'b01) found = (ack_seq == 12'd5);
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL stall_ack: got no ACK with seq 5 expected one within %0d cycles", 2 * T + 8);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    fill_to(5);
    step(1, 9, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    checks++;
    if (dllp_valid !== 1'b1 || ack_nak !== 2'b10) begin
      errors++; $display("FAIL reset_mid_pre: got v=%b an=%b expected v=1 an=10", dllp_valid, ack_nak);
    end
    #2;
    reset = 1;
    #1;
    checks++;
    if (dut_vec !== 30'd0) begin
      errors++; $display("FAIL reset_mid_async: got %h expected %h", dut_vec, 30'd0);
    end
    model_reset();
    @(posedge clk); #1;
    reset = 0;
    for (int j = 0; j < 4; j++) begin
      step(0, 0, 1, 1);
      checks++;
      if (dut_vec !== mdl_vec) begin
        errors++; $display("FAIL reset_mid_after: got %h expected %h", dut_vec, mdl_vec);
      end
    end
  endtask

  task automatic test_random();
    int s;
    bit v, c, r;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      v = ($urandom % 4) != 0;
      if (($urandom % 8) == 0) s = int'($urandom_range(4095, 0));
      else s = (m_next + int'($urandom_range(6, 0)) - 3 + M) % M;
      c = ($urandom % 10) != 0;
      r = ($urandom % 3) != 0;
      step(v, s, c, r);
      checks++;
      if (dut_vec !== mdl_vec) begin
        errors++; $display("FAIL random_cycle%0d: got %h expected %h", i, dut_vec, mdl_vec);
      end
    end
  endtask

  initial begin
    reset = 1; rx_valid = 0; rx_seq = 0; rx_crc_ok = 1; dllp_ready = 0;
    edge_n = 0;
    model_reset();
    test_reset();
    test_in_order();
    test_nak_crc();
    test_duplicate();
    test_ahead();
    test_wrap();
    test_stall();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
